// File: rtl/rll_key_loader.sv
// Streams a key in word by word, then commits it atomically onto the locked core's key bus.
// Optional parity word check over the key words is enabled by defining RLL_KEY_PARITY_EN.
module rll_key_loader #(
   parameter int unsigned KEY_WIDTH  = 32,
   parameter int unsigned WORD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  zeroize,
   input  logic                  in_valid,
   input  logic [WORD_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic [KEY_WIDTH-1:0]  key_out,
   output logic                  key_valid,
   output logic                  busy,
   output logic                  load_err
);

   localparam int unsigned NUM_WORDS = KEY_WIDTH / WORD_WIDTH;
   localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1
`ifdef RLL_KEY_PARITY_EN
      , CHECK = 2'd2
`endif
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [KEY_WIDTH-1:0] staging, staging_nxt, merged_c;
   logic [KEY_WIDTH-1:0] key_nxt;
   logic                 key_valid_nxt;
   logic                 hs_c;

   assign hs_c = in_valid & in_ready;

   // Staging value with the incoming word placed at the current word slot
   always_comb begin
      merged_c = staging;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (cnt == CNT_W'(i)) merged_c[i*WORD_WIDTH +: WORD_WIDTH] = in_data;
      end
   end

`ifdef RLL_KEY_PARITY_EN
   logic                  err_nxt;
   logic [WORD_WIDTH-1:0] parity_c;

   always_comb begin
      parity_c = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         parity_c = parity_c ^ staging[i*WORD_WIDTH +: WORD_WIDTH];
      end
   end
`endif

   // Next-state and datapath updates; zeroize outranks restart, restart outranks a handshake
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      staging_nxt   = staging;
      key_nxt       = key_out;
      key_valid_nxt = key_valid;
`ifdef RLL_KEY_PARITY_EN
      err_nxt       = load_err;
`endif
      if (zeroize) begin
         state_nxt     = IDLE;
         cnt_nxt       = '0;
         staging_nxt   = '0;
         key_nxt       = '0;
         key_valid_nxt = 1'b0;
`ifdef RLL_KEY_PARITY_EN
         err_nxt       = 1'b0;
`endif
      end else if (load_start) begin
         state_nxt   = LOAD;
         cnt_nxt     = '0;
         staging_nxt = '0;
`ifdef RLL_KEY_PARITY_EN
         err_nxt     = 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               if (hs_c) begin
                  staging_nxt = merged_c;
                  cnt_nxt     = cnt + CNT_W'(1);
                  if (cnt == CNT_W'(NUM_WORDS - 1)) begin
                     cnt_nxt = '0;
`ifdef RLL_KEY_PARITY_EN
                     state_nxt = CHECK;
`else
                     key_nxt       = merged_c;
                     key_valid_nxt = 1'b1;
                     staging_nxt   = '0;
                     state_nxt     = IDLE;
`endif
                  end
               end
            end
`ifdef RLL_KEY_PARITY_EN
            CHECK: begin
               if (hs_c) begin
                  if (in_data == parity_c) begin
                     key_nxt       = staging;
                     key_valid_nxt = 1'b1;
                  end else begin
                     err_nxt = 1'b1;
                  end
                  staging_nxt = '0;
                  state_nxt   = IDLE;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // State and output registers; in_ready/busy track the registered state exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         staging   <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         staging   <= staging_nxt;
         key_out   <= key_nxt;
         key_valid <= key_valid_nxt;
         busy      <= (state_nxt != IDLE);
         in_ready  <= (state_nxt != IDLE);
      end
   end

`ifdef RLL_KEY_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) load_err <= 1'b0;
      else        load_err <= err_nxt;
   end
`else
   assign load_err = 1'b0;
`endif

endmodule

// File: doc/rll_key_loader.md
Name: rll_key_loader

Overview:
Loads, holds and clears the 32-bit activation key for a random-logic-locked netlist. The key arrives as a word stream over a valid/ready handshake. It is assembled in a staging register and committed atomically onto the keyIn_* bus of the locked core. The block sits between the key source (secure memory or tester port) and the locked combinational core, so the core only ever sees a complete committed key or all-zeros.

Parameters:
KEY_WIDTH, 32, number of key bits; must be a multiple of WORD_WIDTH
WORD_WIDTH, 8, bits per streamed key word
NUM_WORDS, KEY_WIDTH/WORD_WIDTH, derived; words per key load

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  one-cycle pulse; begins a key load
zeroize  input  1  one-cycle pulse; clears committed key and aborts any load
in_valid  input  1  in_data valid
in_data  input  WORD_WIDTH  key word; first word goes to LSBs
in_ready  output  1  block accepts a word this cycle
key_out  output  KEY_WIDTH  committed key; bit i drives keyIn_0_i of the locked core
key_valid  output  1  key_out holds a committed key
busy  output  1  load in progress
load_err  output  1  sticky; last load failed its check (only with feature enabled)

Behaviour:
- Reset (async, rst_n=0):
  - key_out=0, key_valid=0, busy=0, in_ready=0, load_err=0.
  - staging=0, word counter=0, state=IDLE.
  - Reset mid-load discards the partial key.
- States: IDLE, LOAD, CHECK (present only with the feature enabled).
- IDLE:
  - in_ready=0, busy=0.
  - load_start -> LOAD with counter=0 and staging=0; load_err cleared.
- LOAD:
  - busy=1, in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_data into staging[cnt*WORD_WIDTH +: WORD_WIDTH], then cnt++.
  - No handshake means no change; gaps in in_valid are unlimited.
- Commit (feature disabled):
  - On the handshake with cnt==NUM_WORDS-1, key_out takes the full staging value in the next cycle; key_valid=1 that same cycle.
  - State returns to IDLE; busy=0 in that cycle.
  - Latency from the last word accepted to key_out updated is 1 cycle.
- key_out and key_valid change only on commit, zeroize or reset.
  - During a load the previous committed key and its key_valid stay on the core.
  - key_out never shows a partial key.
- load_start while in LOAD or CHECK restarts the load: counter=0, staging=0; the partial words are discarded.
- zeroize in any state:
  - key_out=0, key_valid=0, load_err=0; state goes to IDLE next cycle.
  - zeroize has priority over load_start and over a handshake in the same cycle; that word is dropped.
- in_ready is combinational from state only (high in LOAD/CHECK); it never depends on in_valid.

Optional Feature:
Macro RLL_KEY_PARITY_EN.
- Defined:
  - After the last key word the FSM enters CHECK and accepts one extra word P, with in_ready=1.
  - If P equals the XOR of all NUM_WORDS key words, commit as above one cycle after P's handshake.
  - Otherwise load_err=1, staging is discarded, and key_out/key_valid are unchanged.
  - Either way the FSM returns to IDLE.
- Undefined:
  - No CHECK state; commit follows the last key word.
  - load_err is tied to 0.

Test Plan:
- Reset asserted during a load after 2 words -> immediately key_out=0, key_valid=0, busy=0, in_ready=0; after release the FSM stays IDLE.
- load_start, then words 0xEF, 0xBE, 0xAD, 0xDE with 3-cycle in_valid gaps -> key_out=0xDEADBEEF and key_valid=1 exactly 1 cycle after the 4th handshake; busy low that cycle.
- Second load of 0x11, 0x22, 0x33, 0x44 with key 0xDEADBEEF committed -> key_out stays 0xDEADBEEF and key_valid stays 1 throughout; key_out becomes 0x44332211 1 cycle after the last word.
- zeroize asserted in the same cycle as the 3rd word's handshake -> word dropped; next cycle key_out=0, key_valid=0, state IDLE; later in_valid is ignored (in_ready=0).
- load_start pulsed after 2 words, then 0x01, 0x02, 0x03, 0x04 -> key_out=0x04030201; the earlier words leave no trace.
- RLL_KEY_PARITY_EN, words 0xEF, 0xBE, 0xAD, 0xDE then P=0x22 -> commit 0xDEADBEEF. Same load with P=0x23 -> load_err=1, key_out/key_valid keep their prior values, FSM IDLE.
